add_share_sched: RTL and testbench
==================================

Name: add_share_sched

Overview:
- Schedules one shared unsigned adder among NUM_REQ requesters.
- Applies SystemVerilog expression-width rules per request:
  - context-determined: operands zero-extended to RES_WIDTH, then added;
  - self-determined (concatenation-wrapped): add at natural width, then zero-extend.
- Sits between lowered expression ops and the result sink.
- Round-robin arbitration, one registered output slot, valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- A_WIDTH, 15, width of operand a.
- B_WIDTH, 16, width of operand b.
- RES_WIDTH, 17, result/assignment-context width (>= max(A_WIDTH,B_WIDTH)).
- ID_WIDTH, $clog2(NUM_REQ), requester id width.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  request pending per requester.
- req_ready_o  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
- req_a_i  in  NUM_REQ*A_WIDTH  operand a, packed, requester i at slice i.
- req_b_i  in  NUM_REQ*B_WIDTH  operand b, packed.
- req_self_i  in  NUM_REQ  1 = self-determined add, 0 = context-determined.
- res_valid_o  out  1  result slot occupied.
- res_ready_i  in  1  sink accepts the result.
- res_data_o  out  RES_WIDTH  sum.
- res_id_o  out  ID_WIDTH  index of the requester that produced res_data_o.
- busy_o  out  1  res_valid_o | (|req_valid_i).

Behaviour:
- Reset (async assert, sync release): res_valid_o=0, res_data_o=0, res_id_o=0, rr pointer=0.
- Slot state machine:
  - EMPTY->FULL on a grant.
  - FULL->EMPTY on res_ready_i with no grant.
  - FULL->FULL on res_ready_i with a simultaneous grant, which is allowed (pass-through refill, full throughput).
  - FULL with !res_ready_i holds data/id stable and grants nothing.
- Grant condition: can_issue = !res_valid_o | res_ready_i.
  - When can_issue, req_ready_o is one-hot on the first asserted req_valid_i at or after the pointer, scanning upward with wrap.
  - Otherwise req_ready_o = 0.
  - req_ready_o is combinational from req_valid_i, the pointer and slot state.
  - req_ready_o never asserts for a requester whose valid is low.
- Pointer update: on a grant to index g, pointer <= (g+1) mod NUM_REQ. No grant, no change.
- Latency: result visible in the cycle after the grant (1-cycle registered).
- Fairness: a continuously valid requester is granted within NUM_REQ issue opportunities.
- Arithmetic, with N = max(A_WIDTH,B_WIDTH):
  - self=0: zext(a,RES) + zext(b,RES), modulo 2^RES_WIDTH.
  - self=1: zext(zext(a,N) + zext(b,N), RES); the carry out of bit N-1 is discarded.
  - No signed handling; operands are always zero-extended.
- Requesters may drop valid without being granted; no state is retained for them.
- Reset mid-operation discards the slot contents; no result is produced for the lost grant.

Decomposition:
- Package add_share_pkg holds:
  - typedef enum logic {ADD_CTX=0, ADD_SELF=1} add_mode_e;
  - function natural_width(a,b) returning max;
  - slot state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: request vector, enable, pointer;
  - outputs: one-hot grant and encoded index;
  - pointer register lives in the parent.
- The adder and extension logic stay in the parent.

Test Plan:
- Width, context-determined: req0 a=15'h7FFF, b=16'hFFFF, self=0, res_ready=1 -> next cycle res_data=17'h17FFE, res_id=0.
- Width, self-determined: same operands, self=1 -> res_data=17'h07FFE (carry dropped, then zero-extended).
- Round robin:
  - stimulus: all four valid continuously, res_ready=1, from reset;
  - response: grants 0,1,2,3,0 on consecutive cycles, and res_id follows one cycle later.
- Backpressure:
  - stimulus: slot full, res_ready=0 for 3 cycles while req2 valid;
  - response: req_ready_o=0 and res_data/res_id stable; on the cycle res_ready=1, req2 is granted and its result appears the next cycle, with no bubble.
- Async reset mid-op:
  - stimulus: rst_ni low for half a cycle while the slot is full;
  - response: res_valid_o drops immediately; after release, pointer=0 and the first grant goes to the lowest valid index.
- Sparse/drop:
  - stimulus: pointer=3, only req1 valid;
  - response: req1 granted, pointer becomes 2; req3 raising and dropping valid during a stall yields no result.

Source files
------------

// File: rtl/add_share_pkg.sv
// add_share_pkg: shared types and helpers for the add_share_sched slice.
//   add_mode_e    - expression-width mode of one add request
//   slot_state_e  - occupancy of the single registered result slot
//   natural_width - natural (self-determined) width of an a+b expression
package add_share_pkg;

    typedef enum logic {
        ADD_CTX  = 1'b0,
        ADD_SELF = 1'b1
    } add_mode_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int unsigned natural_width(input int unsigned a,
                                                  input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i  - request vector
//   en_i   - grant enable; no grant when low
//   ptr_i  - highest-priority index (register kept by the parent)
//   gnt_o  - one-hot grant (all zero when nothing granted)
//   idx_o  - encoded index of the granted request
//   any_o  - a grant was issued
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                en_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                any_o
);

    int unsigned best_off;
    int unsigned best_idx;
    int unsigned off;

    // Distance of each request from the pointer (upward, with wrap); the
    // smallest distance wins.
    always_comb begin
        best_off = NUM_REQ;
        best_idx = 0;
        off      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            off = (i + NUM_REQ - int'(ptr_i)) % NUM_REQ;
            if (en_i && req_i[i] && (off < best_off)) begin
                best_off = off;
                best_idx = i;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = (best_off < NUM_REQ) && (i == best_idx);
        end
        any_o = (best_off < NUM_REQ);
        idx_o = ID_WIDTH'(best_idx);
    end

endmodule

// File: rtl/add_share_sched.sv
// add_share_sched: one shared unsigned adder scheduled round-robin among
// NUM_REQ requesters, with a single registered result slot.
//   clk, rst_ni   - clock, asynchronous active-low reset
//   req_valid_i   - per-requester request pending
//   req_ready_o   - one-hot grant (combinational)
//   req_a_i/b_i   - packed operands, requester i at slice i
//   req_self_i    - 1: self-determined add, 0: context-determined add
//   res_valid_o   - result slot occupied
//   res_ready_i   - sink accepts the result
//   res_data_o    - sum, RES_WIDTH bits
//   res_id_o      - requester that produced res_data_o
//   busy_o        - slot occupied or any request pending
module add_share_sched
    import add_share_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned A_WIDTH   = 15,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned RES_WIDTH = 17,
    parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b_i,
    input  logic [NUM_REQ-1:0]           req_self_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [RES_WIDTH-1:0]         res_data_o,
    output logic [ID_WIDTH-1:0]          res_id_o,
    output logic                         busy_o
);

    localparam int unsigned NAT_W = natural_width(A_WIDTH, B_WIDTH);

    slot_state_e          slot_q, slot_d;
    logic [RES_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;

    logic                 can_issue;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_WIDTH-1:0]  gnt_idx;
    logic                 gnt_any;

    logic [A_WIDTH-1:0]   a_sel;
    logic [B_WIDTH-1:0]   b_sel;
    add_mode_e            mode_sel;
    logic [RES_WIDTH-1:0] ctx_sum;
    logic [NAT_W-1:0]     nat_sum;
    logic [RES_WIDTH-1:0] sum;

    // A full slot can still accept a grant when it drains in the same cycle.
    assign can_issue = (slot_q == SLOT_EMPTY) || res_ready_i;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_i (req_valid_i),
        .en_i  (can_issue),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        mode_sel = ADD_CTX;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel    = req_a_i[i*A_WIDTH +: A_WIDTH];
                b_sel    = req_b_i[i*B_WIDTH +: B_WIDTH];
                mode_sel = add_mode_e'(req_self_i[i]);
            end
        end
    end

    // Context-determined: widen first, keep the carry.
    // Self-determined: add at natural width (carry dropped), then widen.
    always_comb begin
        ctx_sum = RES_WIDTH'(a_sel) + RES_WIDTH'(b_sel);
        nat_sum = NAT_W'(a_sel) + NAT_W'(b_sel);
        sum     = (mode_sel == ADD_SELF) ? RES_WIDTH'(nat_sum) : ctx_sum;
    end

    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        if (gnt_any) begin
            slot_d = SLOT_FULL;
            data_d = sum;
            id_d   = gnt_idx;
            ptr_d  = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
        end else if ((slot_q == SLOT_FULL) && res_ready_i) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= SLOT_EMPTY;
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
        end
    end

    assign req_ready_o = gnt;
    assign res_valid_o = (slot_q == SLOT_FULL);
    assign res_data_o  = data_q;
    assign res_id_o    = id_q;
    assign busy_o      = res_valid_o || (|req_valid_i);

endmodule

// File: tb/tb_add_share_sched.sv
module tb_add_share_sched;

    localparam int NR = 4;
    localparam int AW = 15;
    localparam int BW = 16;
    localparam int RW = 17;
    localparam int IW = 2;
    localparam int NW = 16;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_a;
    logic [NR*BW-1:0]  req_b;
    logic [NR-1:0]     req_self;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_data;
    logic [IW-1:0]     res_id;
    logic              busy;

    add_share_sched #(
        .NUM_REQ   (NR),
        .A_WIDTH   (AW),
        .B_WIDTH   (BW),
        .RES_WIDTH (RW),
        .ID_WIDTH  (IW)
    ) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_self_i  (req_self),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_id_o    (res_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] a_arr [NR];
    logic [BW-1:0] b_arr [NR];

    // Reference model state: what the sink should see.
    int     m_ptr;
    bit     m_valid;
    longint m_data;
    int     m_id;
    logic [NR-1:0] last_ready;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        bit            self_mode;
        longint        exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_grant();
        int idx;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic longint ref_sum(input longint a, input longint b, input bit s);
        if (s) return (a + b) % (64'd1 << NW);
        return (a + b) % (64'd1 << RW);
    endfunction

    // Called at posedge+1; ends at the next posedge+1.
    task automatic step();
        int g;
        logic [NR-1:0] eg;
        for (int i = 0; i < NR; i++) begin
            req_a[i*AW +: AW] = a_arr[i];
            req_b[i*BW +: BW] = b_arr[i];
        end
        #2;
        g  = ref_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        last_ready = req_ready;
        chk("req_ready", req_ready, eg);
        chk("busy", busy, m_valid | (|req_valid));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = ref_sum(a_arr[g], b_arr[g], req_self[g]);
            m_id    = g;
            m_ptr   = (g + 1) % NR;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("res_valid", res_valid, m_valid);
        if (m_valid) begin
            chk("res_data", res_data, m_data);
            chk("res_id", res_id, m_id);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = 0; m_id = 0;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        req_valid = '0;
        req_self  = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        req_a = '0;
        req_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [RW-1:0] held_data;
        logic [IW-1:0] held_id;
        int r;

        tbl[0] = '{15'h7FFF, 16'hFFFF, 1'b0, 64'h17FFE};
        tbl[1] = '{15'h7FFF, 16'hFFFF, 1'b1, 64'h07FFE};
        tbl[2] = '{15'h0000, 16'h0000, 1'b0, 64'h00000};
        tbl[3] = '{15'h0001, 16'hFFFF, 1'b0, 64'h10000};
        tbl[4] = '{15'h0001, 16'hFFFF, 1'b1, 64'h00000};
        tbl[5] = '{15'h1234, 16'h4321, 1'b1, 64'h05555};
        tbl[6] = '{15'h7FFF, 16'h8001, 1'b0, 64'h10000};

        do_reset();
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);

        // Table-driven arithmetic vectors, one requester at a time.
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            r = (i == 1) ? 0 : i % NR;
            req_valid       = '0;
            a_arr[r]        = tbl[i].a;
            b_arr[r]        = tbl[i].b;
            req_self[r]     = tbl[i].self_mode;
            req_valid[r]    = 1'b1;
            step();
            chk("tbl_data", res_data, tbl[i].exp);
            chk("tbl_id", res_id, r);
            req_valid = '0;
        end
        step();

        // Round robin from reset, all requesters valid.
        do_reset();
        res_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_grant", last_ready, 64'd1 << (k % NR));
            chk("rr_id", res_id, k % NR);
        end

        // Backpressure: slot full, sink stalled, req2 waiting.
        req_valid = 4'b0100;
        res_ready = 1'b0;
        held_data = res_data;
        held_id   = res_id;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready", last_ready, 0);
            chk("bp_data_hold", res_data, held_data);
            chk("bp_id_hold", res_id, held_id);
        end
        res_ready = 1'b1;
        step();
        chk("bp_grant", last_ready, 4'b0100);
        chk("bp_nobubble", res_valid, 1);
        chk("bp_id", res_id, 2);

        // Async reset while the slot is full.
        res_ready = 1'b0;
        #1;
        rst_ni    = 1'b0;
        req_valid = '0;
        #1;
        chk("arst_valid", res_valid, 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b0110;
        res_ready = 1'b1;
        step();
        chk("arst_first", last_ready, 4'b0010);

        // Sparse: move pointer to 3, then only req1 valid.
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0010;
        step();
        chk("sparse_grant", last_ready, 4'b0010);
        req_valid = 4'b0110;
        step();
        chk("sparse_ptr2", last_ready, 4'b0100);
        // Requester 3 pulses valid during a stall and then withdraws.
        res_ready = 1'b0;
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        step();
        res_ready = 1'b1;
        step();
        step();
        chk("drop_noresult", res_valid, 0);
        chk("drop_id", res_id, 2);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid = NR'($urandom_range(0, 15));
            req_self  = NR'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                a_arr[i] = AW'($urandom);
                b_arr[i] = BW'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
